// File: rtl/sm83_prefetch.sv
// Instruction-byte prefetcher: walks fetch_pc over the shared read port, queues
// {byte, address} pairs in a small FIFO and hands them to the decoder.
module sm83_prefetch #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          mem_req_o,
  input  logic                          mem_grant_i,
  output logic [15:0]                   mem_r_addr_o,
  input  logic [7:0]                    mem_r_data_i,
  input  logic                          redirect_valid_i,
  input  logic [15:0]                   redirect_pc_i,
  output logic                          out_valid_o,
  output logic [7:0]                    out_data_o,
  output logic [15:0]                   out_pc_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_C = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] pc;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [15:0]   pc_q, pc_d;
  logic [LW-1:0] count;
  logic          push, pop;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign count        = wr_q - rd_q;
  assign mem_req_o    = (count < DEPTH_C) && !redirect_valid_i;
  assign out_valid_o  = (count != '0) && !redirect_valid_i;
  assign push         = mem_req_o && mem_grant_i;
  assign pop          = out_valid_o && out_ready_i;
  assign mem_r_addr_o = pc_q;
  assign fifo_level_o = count;
  assign out_data_o   = fifo_q[rd_q[AW-1:0]].data;
  assign out_pc_o     = fifo_q[rd_q[AW-1:0]].pc;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    pc_d = pc_q;
    if (redirect_valid_i) begin
      wr_d = '0;
      rd_d = '0;
      pc_d = redirect_pc_i;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
        pc_d = pc_q + 16'd1;
      end
      if (pop) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      pc_q <= RESET_PC;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      pc_q <= pc_d;
    end
  end

  // Entry storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[AW-1:0]] <= '{data: mem_r_data_i, pc: pc_q};
  end

endmodule

// File: tb/tb_sm83_prefetch.sv
// Self-checking bench for sm83_prefetch: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sm83_prefetch;

  localparam int FD = 4;

  logic        clk, rst_n;
  logic        mem_req, mem_grant, redir, out_valid, out_ready;
  logic [15:0] mem_r_addr, redir_pc, out_pc;
  logic [7:0]  mem_r_data, out_data;
  logic [2:0]  fifo_level;

  logic [7:0] mem [65536];

  sm83_prefetch #(.FIFO_DEPTH(FD), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req), .mem_grant_i(mem_grant),
    .mem_r_addr_o(mem_r_addr), .mem_r_data_i(mem_r_data),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_pc_o(out_pc),
    .out_ready_i(out_ready), .fifo_level_o(fifo_level)
  );

  assign mem_r_data = mem[mem_r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of fetched {pc, byte} records.
  typedef struct {
    logic [15:0] pc;
    logic [7:0]  data;
  } ent_t;
  ent_t        mq[$];
  logic [15:0] mpc;

  task automatic model_reset();
    mq.delete();
    mpc = 16'h0000;
  endtask

  // Compare DUT with the model for the current inputs, then advance the model.
  task automatic model_step();
    bit ev, ereq;
    ev   = (mq.size() != 0) && !redir;
    ereq = (mq.size() < FD) && !redir;
    chk("m_valid", 32'(out_valid), 32'(ev));
    chk("m_req",   32'(mem_req),   32'(ereq));
    chk("m_addr",  32'(mem_r_addr), 32'(mpc));
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    if (ev) begin
      chk("m_pc",   32'(out_pc),   32'(mq[0].pc));
      chk("m_data", 32'(out_data), 32'(mq[0].data));
    end
    if (redir) begin
      mq.delete();
      mpc = redir_pc;
    end else begin
      if (ev && out_ready) void'(mq.pop_front());
      if (ereq && mem_grant) begin
        mq.push_back('{pc: mpc, data: mem[mpc]});
        mpc = mpc + 16'd1;
      end
    end
  endtask

  task automatic drive(input bit g, input bit r, input bit rv, input logic [15:0] rp);
    mem_grant = g; out_ready = r; redir = rv; redir_pc = rp;
    @(negedge clk);
    model_step();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          g, r, ev;
    logic [15:0] epc;
    logic [7:0]  ed;
    int          elvl;
    bit          ereq;
    logic [15:0] eaddr;
  } vec_t;
  vec_t tbl[13];

  initial begin
    // Fill from reset with ready low, then stream with grant patterns.
    tbl[0]  = '{1, 0, 0, 16'h0000, 8'h00, 0, 1, 16'h0000};
    tbl[1]  = '{1, 0, 1, 16'h0000, 8'h00, 1, 1, 16'h0001};
    tbl[2]  = '{1, 0, 1, 16'h0000, 8'h00, 2, 1, 16'h0002};
    tbl[3]  = '{1, 0, 1, 16'h0000, 8'h00, 3, 1, 16'h0003};
    tbl[4]  = '{1, 0, 1, 16'h0000, 8'h00, 4, 0, 16'h0004};
    tbl[5]  = '{1, 1, 1, 16'h0000, 8'h00, 4, 0, 16'h0004};
    tbl[6]  = '{1, 1, 1, 16'h0001, 8'h01, 3, 1, 16'h0004};
    tbl[7]  = '{1, 1, 1, 16'h0002, 8'hFF, 3, 1, 16'h0005};
    tbl[8]  = '{1, 1, 1, 16'h0003, 8'hFF, 3, 1, 16'h0006};
    tbl[9]  = '{0, 1, 1, 16'h0004, 8'hFF, 3, 1, 16'h0007};
    tbl[10] = '{1, 1, 1, 16'h0005, 8'hFF, 2, 1, 16'h0007};
    tbl[11] = '{0, 1, 1, 16'h0006, 8'hFF, 2, 1, 16'h0008};
    tbl[12] = '{1, 1, 1, 16'h0007, 8'hFF, 1, 1, 16'h0008};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    mem[0] = 8'h00;
    mem[1] = 8'h01;
    mem[16'h0040] = 8'hA5;

    rst_n = 1'b0; mem_grant = 1'b1; out_ready = 1'b0; redir = 1'b0; redir_pc = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_addr",  32'(mem_r_addr), 0);
    chk("rst_req",   32'(mem_req), 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].g, tbl[i].r, 1'b0, 16'h0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].elvl));
      chk($sformatf("tbl%0d_req", i),   32'(mem_req),    32'(tbl[i].ereq));
      chk($sformatf("tbl%0d_addr", i),  32'(mem_r_addr), 32'(tbl[i].eaddr));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i),   32'(out_pc),   32'(tbl[i].epc));
        chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      end
      fin();
    end

    // Three buffered entries, then redirect to 0040 while ready is high.
    drive(1, 0, 1, 16'h0100); fin();
    repeat (3) begin drive(1, 0, 0, 16'h0); fin(); end
    drive(1, 1, 1, 16'h0040);
    chk("rd40_valid_N", 32'(out_valid), 0);
    fin();
    drive(1, 1, 0, 16'h0);
    chk("rd40_valid_N1", 32'(out_valid), 0);
    chk("rd40_addr_N1",  32'(mem_r_addr), 32'h0040);
    chk("rd40_level_N1", 32'(fifo_level), 0);
    fin();
    drive(1, 1, 0, 16'h0);
    chk("rd40_valid_N2", 32'(out_valid), 1);
    chk("rd40_pc_N2",    32'(out_pc), 32'h0040);
    chk("rd40_data_N2",  32'(out_data), 32'hA5);
    fin();

    // 16-bit wrap of fetch_pc.
    drive(1, 1, 1, 16'hFFFE); fin();
    drive(1, 1, 0, 16'h0); fin();
    begin
      logic [15:0] wexp [4];
      wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
      for (int i = 0; i < 4; i++) begin
        drive(1, 1, 0, 16'h0);
        chk($sformatf("wrap%0d_valid", i), 32'(out_valid), 1);
        chk($sformatf("wrap%0d_pc", i),    32'(out_pc), 32'(wexp[i]));
        fin();
      end
    end

    // Reset with the FIFO full.
    repeat (6) begin drive(1, 0, 0, 16'h0); fin(); end
    chk("full_level", 32'(fifo_level), 4);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_addr",  32'(mem_r_addr), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 16'h0); fin();
    drive(1, 1, 0, 16'h0);
    chk("arst_first_valid", 32'(out_valid), 1);
    chk("arst_first_pc",    32'(out_pc), 0);
    fin();

    // Randomized traffic against the model.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      bit g, r, rv;
      logic [15:0] rp;
      g  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 24) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      drive(g, r, rv, rp);
      fin();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
